// File: rtl/tetris_pkg.sv
// Shared constants, FSM/operation encodings and the piece shape table for the falling-piece controller.
package tetris_pkg;

  localparam int FIELD_W = 20;
  localparam int FIELD_H = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_CHECK,
    ST_COMMIT,
    ST_READY,
    ST_LOCK,
    ST_OVER
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_SPAWN,
    OP_ROT,
    OP_LEFT,
    OP_RIGHT,
    OP_DOWN,
    OP_TICK,
    OP_HARD
  } op_t;

  // 4x4 occupancy mask, bit r*4+c. Ids: 0=I 1=O 2=T 3=S 4=Z 5=J 6=L; 7 falls back to O so a mask is never empty.
  function automatic logic [15:0] piece_mask(input logic [2:0] id, input logic [1:0] rot);
    logic [15:0] m;
    case ({id, rot})
      5'b000_00: m = 16'h00F0;
      5'b000_01: m = 16'h4444;
      5'b000_10: m = 16'h0F00;
      5'b000_11: m = 16'h2222;
      5'b010_00: m = 16'h0072;
      5'b010_01: m = 16'h0262;
      5'b010_10: m = 16'h0270;
      5'b010_11: m = 16'h0232;
      5'b011_00: m = 16'h0036;
      5'b011_01: m = 16'h0462;
      5'b011_10: m = 16'h0360;
      5'b011_11: m = 16'h0231;
      5'b100_00: m = 16'h0063;
      5'b100_01: m = 16'h0264;
      5'b100_10: m = 16'h0630;
      5'b100_11: m = 16'h0132;
      5'b101_00: m = 16'h0071;
      5'b101_01: m = 16'h0226;
      5'b101_10: m = 16'h0470;
      5'b101_11: m = 16'h0322;
      5'b110_00: m = 16'h0074;
      5'b110_01: m = 16'h0622;
      5'b110_10: m = 16'h0170;
      5'b110_11: m = 16'h0223;
      default:   m = 16'h0066;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/piece_collide.sv
// Registered 16-cell collision checker: tests a candidate box position/mask against walls, floor and
// the settled-field occupancy map; the result is captured when en is high.
module piece_collide
  import tetris_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [4:0]                   x,
  input  logic [4:0]                   y,
  input  logic [15:0]                  mask,
  input  logic [FIELD_W*FIELD_H-1:0]   field_occ,
  output logic                         hit
);

  localparam logic [5:0] W6 = 6'(FIELD_W);
  localparam logic [5:0] H6 = 6'(FIELD_H);

  logic hit_c;

  always_comb begin
    // NOTE: default assignment first, so no path leaves hit_c unassigned and no latch is inferred.
    hit_c = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        logic [5:0] cx;
        logic [5:0] ry;
        logic [8:0] idx;
        // 6-bit sums so a box hanging past column/row 31 cannot wrap back into the field.
        cx  = {1'b0, x} + 6'(c);
        ry  = {1'b0, y} + 6'(r);
        idx = 9'(ry) * 9'(FIELD_W) + 9'(cx);
        if (mask[r*4+c]) begin
          if (cx >= W6 || ry >= H6) hit_c = 1'b1;
          else if (field_occ[idx])  hit_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
    if (!rst_n)  hit <= 1'b0;
    else if (en) hit <= hit_c;
  end

endmodule

// File: rtl/piece_move_ctrl.sv
// Falling-piece sequencer: arbitrates move requests against gravity, checks candidates, commits moves.
// Optional `HARD_DROP_EN adds req_hard, dropping the piece to its resting row in one request.
module piece_move_ctrl
  import tetris_pkg::*;
#(
  parameter int SPAWN_X = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [2:0]                   piece_id,
  input  logic                         req_left,
  input  logic                         req_right,
  input  logic                         req_rot,
  input  logic                         req_down,
  input  logic                         tick,
`ifdef HARD_DROP_EN
  input  logic                         req_hard,
`endif
  input  logic [FIELD_W*FIELD_H-1:0]   field_occ,
  output logic [4:0]                   block_pos_x,
  output logic [4:0]                   block_pos_y,
  output logic [9:0]                   rotate,
  output logic [15:0]                  block_matrix,
  output logic                         disp_en,
  output logic                         lock_pulse,
  output logic                         game_over,
  output logic                         busy
);

  state_t      state;
  op_t         sel_op, op_q;
  logic [2:0]  piece_q, nxt_piece;
  logic [4:0]  nxt_x, nxt_y, cand_x, cand_y;
  logic [1:0]  nxt_rot, cand_rot;
  logic [15:0] nxt_mask, cand_mask;
  logic        go_check, hit, hard_in;
  logic        pend_rot, pend_left, pend_right, pend_down, pend_tick, pend_hard;
  logic        clr_rot, clr_left, clr_right, clr_down, clr_tick, clr_hard, clr_all;

`ifdef HARD_DROP_EN
  assign hard_in = req_hard;
`else
  assign hard_in = 1'b0;
`endif

  // Candidate selection: built in SPAWN/READY (or by the hard-drop loop) and checked on entry to CHECK.
  always_comb begin
    sel_op    = OP_NONE;
    nxt_x     = block_pos_x;
    nxt_y     = block_pos_y;
    nxt_rot   = rotate[1:0];
    nxt_piece = piece_q;
    go_check  = 1'b0;
    clr_rot   = 1'b0;
    clr_left  = 1'b0;
    clr_right = 1'b0;
    clr_down  = 1'b0;
    clr_tick  = 1'b0;
    clr_hard  = 1'b0;
    clr_all   = (state == ST_CHECK) && (op_q == OP_SPAWN) && hit;

    if      (pend_rot)   sel_op = OP_ROT;
    else if (pend_hard)  sel_op = OP_HARD;
    else if (pend_left)  sel_op = OP_LEFT;
    else if (pend_right) sel_op = OP_RIGHT;
    else if (pend_down)  sel_op = OP_DOWN;
    else if (pend_tick)  sel_op = OP_TICK;

    case (state)
      ST_SPAWN: begin
        nxt_x     = 5'(SPAWN_X);
        nxt_y     = 5'd0;
        nxt_rot   = 2'd0;
        nxt_piece = piece_id;
        go_check  = 1'b1;
      end
      ST_READY: begin
        go_check = (sel_op != OP_NONE);
        case (sel_op)
          OP_ROT:   begin nxt_rot = rotate[1:0] + 2'd1; clr_rot = 1'b1; end
          OP_HARD:  begin nxt_y = block_pos_y + 5'd1; clr_hard = 1'b1; end
          OP_LEFT: begin
            clr_left = 1'b1;
            // Left from column 0 is refused here rather than underflowing into a huge x.
            if (block_pos_x == 5'd0) go_check = 1'b0;
            else                     nxt_x = block_pos_x - 5'd1;
          end
          OP_RIGHT: begin nxt_x = block_pos_x + 5'd1; clr_right = 1'b1; end
          OP_DOWN:  begin nxt_y = block_pos_y + 5'd1; clr_down = 1'b1; clr_tick = 1'b1; end
          OP_TICK:  begin nxt_y = block_pos_y + 5'd1; clr_tick = 1'b1; end
          default:  ;
        endcase
      end
      ST_CHECK: begin
        if (op_q == OP_HARD && !hit) begin
          nxt_x    = cand_x;
          nxt_y    = cand_y + 5'd1;
          nxt_rot  = cand_rot;
          go_check = 1'b1;
        end
      end
      default: ;
    endcase

    nxt_mask = piece_mask(nxt_piece, nxt_rot);
  end

  piece_collide u_collide (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (go_check),
    .x         (nxt_x),
    .y         (nxt_y),
    .mask      (nxt_mask),
    .field_occ (field_occ),
    .hit       (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {pend_rot, pend_left, pend_right, pend_down, pend_tick, pend_hard} <= '0;
    end else if (clr_all) begin
      {pend_rot, pend_left, pend_right, pend_down, pend_tick, pend_hard} <= '0;
    end else begin
      pend_rot   <= req_rot   | (pend_rot   & ~clr_rot);
      pend_left  <= req_left  | (pend_left  & ~clr_left);
      pend_right <= req_right | (pend_right & ~clr_right);
      pend_down  <= req_down  | (pend_down  & ~clr_down);
      pend_tick  <= tick      | (pend_tick  & ~clr_tick);
      pend_hard  <= hard_in   | (pend_hard  & ~clr_hard);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= OP_NONE;
      piece_q      <= 3'd0;
      cand_x       <= 5'd0;
      cand_y       <= 5'd0;
      cand_rot     <= 2'd0;
      cand_mask    <= 16'd0;
      block_pos_x  <= 5'd0;
      block_pos_y  <= 5'd0;
      rotate       <= 10'd0;
      block_matrix <= 16'd0;
      disp_en      <= 1'b0;
      lock_pulse   <= 1'b0;
      game_over    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      disp_en    <= 1'b0;
      lock_pulse <= 1'b0;

      if (go_check) begin
        cand_x    <= nxt_x;
        cand_y    <= nxt_y;
        cand_rot  <= nxt_rot;
        cand_mask <= nxt_mask;
        if (state == ST_SPAWN)      op_q <= OP_SPAWN;
        else if (state == ST_READY) op_q <= sel_op;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SPAWN;
            busy  <= 1'b1;
          end
        end
        ST_SPAWN: begin
          piece_q <= piece_id;
          state   <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!hit) begin
            if (op_q == OP_HARD) begin
              // Silent step; the loop re-checks one row lower next cycle.
              block_pos_y <= cand_y;
            end else begin
              block_pos_x  <= cand_x;
              block_pos_y  <= cand_y;
              rotate       <= {8'd0, cand_rot};
              block_matrix <= cand_mask;
              state        <= ST_COMMIT;
            end
          end else begin
            case (op_q)
              OP_SPAWN: begin
                game_over <= 1'b1;
                state     <= ST_OVER;
              end
              OP_DOWN, OP_TICK: begin
                lock_pulse <= 1'b1;
                state      <= ST_LOCK;
              end
              OP_HARD: begin
                disp_en    <= 1'b1;
                lock_pulse <= 1'b1;
                state      <= ST_LOCK;
              end
              default: begin
                busy  <= 1'b0;
                state <= ST_READY;
              end
            endcase
          end
        end
        ST_COMMIT: begin
          disp_en <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_READY;
        end
        ST_READY: begin
          if (go_check) begin
            busy  <= 1'b1;
            state <= ST_CHECK;
          end
        end
        ST_LOCK: state <= ST_SPAWN;
        ST_OVER: begin
          if (start) begin
            game_over <= 1'b0;
            state     <= ST_SPAWN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed bench for piece_move_ctrl: spawn, lateral limits, gravity/drop merge, lock, game over, async reset.
module tb_piece_move_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   piece_id;
  logic         req_left, req_right, req_rot, req_down, tick;
  logic         req_hard;
  logic [399:0] field_occ;
  logic [4:0]   block_pos_x, block_pos_y;
  logic [9:0]   rotate;
  logic [15:0]  block_matrix;
  logic         disp_en, lock_pulse, game_over, busy;

  int checks = 0;
  int errors = 0;
  int disp_cnt = 0;
  int lock_cnt = 0;
  int lock_y = -1;
  int d0;

  localparam logic [4:0] P_ROT = 5'b10000, P_LEFT = 5'b01000, P_RIGHT = 5'b00100,
                         P_DOWN = 5'b00010, P_TICK = 5'b00001;

  always #5 clk = ~clk;

  piece_move_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .piece_id     (piece_id),
    .req_left     (req_left),
    .req_right    (req_right),
    .req_rot      (req_rot),
    .req_down     (req_down),
    .tick         (tick),
`ifdef HARD_DROP_EN
    .req_hard     (req_hard),
`endif
    .field_occ    (field_occ),
    .block_pos_x  (block_pos_x),
    .block_pos_y  (block_pos_y),
    .rotate       (rotate),
    .block_matrix (block_matrix),
    .disp_en      (disp_en),
    .lock_pulse   (lock_pulse),
    .game_over    (game_over),
    .busy         (busy)
  );

  always @(negedge clk) begin
    if (disp_en) disp_cnt++;
    if (lock_pulse) begin
      lock_cnt++;
      lock_y = int'(block_pos_y);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic [4:0] which);
    {req_rot, req_left, req_right, req_down, tick} = which;
    step();
    {req_rot, req_left, req_right, req_down, tick} = 5'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [39:0] all_outs();
    return {block_pos_x, block_pos_y, rotate, block_matrix, disp_en, lock_pulse, game_over, busy};
  endfunction

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    piece_id = 3'd1;
    {req_rot, req_left, req_right, req_down, tick} = 5'b0;
    req_hard = 1'b0;
    field_occ = '0;
    idle(3);
    check("reset_outputs", 64'(all_outs()), 64'd0);
    rst_n = 1'b1;
    idle(3);
    check("idle_no_start", 64'({busy, disp_cnt[7:0]}), 64'd0);

    // Spawn O on an empty field: outputs visible in COMMIT, disp_en and busy low one cycle later.
    pulse_start();
    idle(2);
    check("spawn_busy_commit", 64'(busy), 64'd1);
    check("spawn_pos", 64'({block_pos_x, block_pos_y}), 64'({5'd8, 5'd0}));
    check("spawn_matrix", 64'(block_matrix), 64'h0066);
    idle(1);
    check("spawn_busy_ready", 64'(busy), 64'd0);
    check("spawn_disp_en", 64'(disp_en), 64'd1);
    idle(2);
    check("spawn_disp_once", 64'(disp_cnt), 64'd1);

    // Nine lefts from x=8: eight moves, the ninth refused at column 0 with no disp_en.
    for (int i = 1; i <= 9; i++) begin
      d0 = disp_cnt;
      pulse(P_LEFT);
      idle(5);
      check("left_x", 64'(block_pos_x), 64'((i <= 8) ? 8 - i : 0));
      check("left_disp", 64'(disp_cnt - d0), 64'((i <= 8) ? 1 : 0));
    end

    pulse(P_RIGHT);
    idle(5);
    check("right_x", 64'(block_pos_x), 64'd1);

    // rot and left pending together: rotation commits first, left follows.
    pulse(P_ROT | P_LEFT);
    idle(2);
    check("prio_rot_first", 64'({rotate, block_pos_x}), 64'({10'd1, 5'd1}));
    idle(6);
    check("prio_left_second", 64'({rotate, block_pos_x}), 64'({10'd1, 5'd0}));

    for (int i = 0; i < 5; i++) begin
      pulse(P_DOWN);
      idle(5);
    end
    check("down_to_5", 64'(block_pos_y), 64'd5);

    // tick and down in the same cycle merge into a single one-row step.
    d0 = disp_cnt;
    pulse(P_DOWN | P_TICK);
    idle(5);
    check("merge_y", 64'(block_pos_y), 64'd6);
    idle(10);
    check("merge_y_hold", 64'(block_pos_y), 64'd6);
    check("merge_disp", 64'(disp_cnt - d0), 64'd1);

    // Asynchronous reset while a right move is in CHECK.
    d0 = disp_cnt;
    pulse(P_RIGHT);
    step();
    check("rst_in_check_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 64'(all_outs()), 64'd0);
    step();
    rst_n = 1'b1;
    idle(6);
    check("rst_release_idle", 64'({busy, block_pos_x, game_over}), 64'd0);
    check("rst_no_pulse", 64'(disp_cnt - d0), 64'd0);

    // Spawn area blocked: game over, no display; start again on a clear field recovers.
    for (int y = 0; y < 2; y++)
      for (int x = 8; x < 12; x++) field_occ[y*20+x] = 1'b1;
    d0 = disp_cnt;
    pulse_start();
    idle(5);
    check("over_flag", 64'({game_over, busy}), 64'b11);
    check("over_no_disp", 64'(disp_cnt - d0), 64'd0);
    field_occ = '0;
    pulse_start();
    idle(5);
    check("over_restart", 64'({game_over, busy, block_pos_x, block_pos_y}), 64'({2'b00, 5'd8, 5'd0}));
    check("over_restart_disp", 64'(disp_cnt - d0), 64'd1);

    // Vertical I falling onto a full row 19 locks at y=15, then the next piece spawns.
    do_reset();
    for (int x = 0; x < 20; x++) field_occ[19*20+x] = 1'b1;
    piece_id = 3'd0;
    pulse_start();
    idle(6);
    check("i_spawn_matrix", 64'(block_matrix), 64'h00F0);
    pulse(P_ROT);
    idle(5);
    check("i_vertical", 64'({rotate, block_matrix}), 64'({10'd1, 16'h4444}));
    for (int i = 0; i < 15; i++) begin
      pulse(P_TICK);
      idle(5);
    end
    check("i_fall_y", 64'({block_pos_y, lock_cnt[3:0]}), 64'({5'd15, 4'd0}));
    piece_id = 3'd1;
    pulse(P_TICK);
    idle(8);
    check("lock_count", 64'(lock_cnt), 64'd1);
    check("lock_y", 64'(lock_y), 64'd15);
    check("respawn", 64'({block_pos_x, block_pos_y, rotate, block_matrix, busy}),
          64'({5'd8, 5'd0, 10'd0, 16'h0066, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
